// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl
// Summary  : ID-stage immediate select, load-use bubble / redirect flush
//            control, registered EX forwarding selects and event counters.
// Revision : 1.0
// ============================================================================
module id_hazard_ctrl (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        ex_valid,
    input  logic        ex_rf_we,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        mem_valid,
    input  logic        mem_rf_we,
    input  logic [4:0]  mem_rd,
    input  logic        ex_redirect,
    output logic [2:0]  sext_op,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a_ex,
    output logic [1:0]  fwd_b_ex,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [2:0] c_EXT_NONE = 3'd0;
    localparam logic [2:0] c_EXT_I    = 3'd1;
    localparam logic [2:0] c_EXT_S    = 3'd2;
    localparam logic [2:0] c_EXT_B    = 3'd3;
    localparam logic [2:0] c_EXT_U    = 3'd4;
    localparam logic [2:0] c_EXT_J    = 3'd5;

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_MEM = 2'b01;
    localparam logic [1:0] c_FWD_WB  = 2'b10;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_fwd_a;
    logic [1:0]  r_fwd_b;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_ex_rs1, w_ex_rs2, w_mem_rs1, w_mem_rs2;
    logic        w_load_use;
    logic        w_redirect;
    logic        w_bubble;
    logic [1:0]  w_fwd_a_nxt;
    logic [1:0]  w_fwd_b_nxt;

    assign w_opcode = id_inst[6:0];
    assign w_rs1    = id_inst[19:15];
    assign w_rs2    = id_inst[24:20];

    always_comb begin
        case (w_opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR: sext_op = c_EXT_I;
            c_OP_STORE:                     sext_op = c_EXT_S;
            c_OP_BR:                        sext_op = c_EXT_B;
            c_OP_LUI, c_OP_AUIPC:           sext_op = c_EXT_U;
            c_OP_JAL:                       sext_op = c_EXT_J;
            default:                        sext_op = c_EXT_NONE;
        endcase
    end

    assign w_uses_rs1 = (w_opcode != c_OP_LUI) && (w_opcode != c_OP_AUIPC) &&
                        (w_opcode != c_OP_JAL);
    assign w_uses_rs2 = (w_opcode == c_OP_R) || (w_opcode == c_OP_STORE) ||
                        (w_opcode == c_OP_BR);

    // x0 is hardwired, so a producer targeting it never creates a dependency.
    assign w_ex_rs1  = ex_valid  && ex_rf_we  && (ex_rd  != 5'd0) && (ex_rd  == w_rs1);
    assign w_ex_rs2  = ex_valid  && ex_rf_we  && (ex_rd  != 5'd0) && (ex_rd  == w_rs2);
    assign w_mem_rs1 = mem_valid && mem_rf_we && (mem_rd != 5'd0) && (mem_rd == w_rs1);
    assign w_mem_rs2 = mem_valid && mem_rf_we && (mem_rd != 5'd0) && (mem_rd == w_rs2);

    assign w_load_use = (r_state == S_RUN) && id_valid && ex_is_load &&
                        ((w_uses_rs1 && w_ex_rs1) || (w_uses_rs2 && w_ex_rs2));

    assign w_redirect = cpu_rst_n && ex_redirect;
    assign w_bubble   = cpu_rst_n && !ex_redirect && w_load_use;

    assign pc_stall   = w_bubble;
    assign ifid_stall = w_bubble;
    assign ifid_flush = w_redirect;
    assign idex_flush = w_redirect || w_bubble;

    always_comb begin
        w_fwd_a_nxt = c_FWD_RF;
        w_fwd_b_nxt = c_FWD_RF;
        if (w_uses_rs1 && w_ex_rs1)       w_fwd_a_nxt = c_FWD_MEM;
        else if (w_uses_rs1 && w_mem_rs1) w_fwd_a_nxt = c_FWD_WB;
        if (w_uses_rs2 && w_ex_rs2)       w_fwd_b_nxt = c_FWD_MEM;
        else if (w_uses_rs2 && w_mem_rs2) w_fwd_b_nxt = c_FWD_WB;
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            r_state     <= S_RUN;
            r_fwd_a     <= c_FWD_RF;
            r_fwd_b     <= c_FWD_RF;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_redirect) begin
                r_state <= S_RUN;
                if (r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
            end else if (w_bubble) begin
                r_state <= S_STALL;
                if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
            end else begin
                r_state <= S_RUN;
            end

            if (idex_flush) begin
                r_fwd_a <= c_FWD_RF;
                r_fwd_b <= c_FWD_RF;
            end else begin
                r_fwd_a <= w_fwd_a_nxt;
                r_fwd_b <= w_fwd_b_nxt;
            end
        end
    end

    assign fwd_a_ex  = r_fwd_a;
    assign fwd_b_ex  = r_fwd_b;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_hazard_ctrl
// Summary  : Directed vector table plus hand sequences for id_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_id_hazard_ctrl;

    localparam logic [2:0] c_EXT_NONE = 3'd0;
    localparam logic [2:0] c_EXT_I    = 3'd1;
    localparam logic [2:0] c_EXT_S    = 3'd2;
    localparam logic [2:0] c_EXT_B    = 3'd3;
    localparam logic [2:0] c_EXT_U    = 3'd4;
    localparam logic [2:0] c_EXT_J    = 3'd5;

    localparam logic [6:0] c_R  = 7'b0110011;
    localparam logic [6:0] c_I  = 7'b0010011;
    localparam logic [6:0] c_LD = 7'b0000011;
    localparam logic [6:0] c_JR = 7'b1100111;
    localparam logic [6:0] c_S  = 7'b0100011;
    localparam logic [6:0] c_B  = 7'b1100011;
    localparam logic [6:0] c_LU = 7'b0110111;
    localparam logic [6:0] c_AU = 7'b0010111;
    localparam logic [6:0] c_J  = 7'b1101111;

    // ctl = {pc_stall, ifid_stall, ifid_flush, idex_flush}; fwd = {a, b}
    localparam logic [3:0] c_CTL_NONE  = 4'b0000;
    localparam logic [3:0] c_CTL_STALL = 4'b1101;
    localparam logic [3:0] c_CTL_REDIR = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        ex_valid, ex_rf_we, ex_is_load;
    logic [4:0]  ex_rd;
    logic        mem_valid, mem_rf_we;
    logic [4:0]  mem_rd;
    logic        ex_redirect;
    logic [2:0]  sext_op;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic [1:0]  fwd_a_ex, fwd_b_ex;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl dut (
        .cpu_clk    (clk),
        .cpu_rst_n  (rst_n),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .ex_valid   (ex_valid),
        .ex_rf_we   (ex_rf_we),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .mem_valid  (mem_valid),
        .mem_rf_we  (mem_rf_we),
        .mem_rd     (mem_rd),
        .ex_redirect(ex_redirect),
        .sext_op    (sext_op),
        .pc_stall   (pc_stall),
        .ifid_stall (ifid_stall),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .fwd_a_ex   (fwd_a_ex),
        .fwd_b_ex   (fwd_b_ex),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    typedef struct {
        logic        idv;
        logic [31:0] inst;
        logic        exv, exwe, exld;
        logic [4:0]  exrd;
        logic        memv, memwe;
        logic [4:0]  memrd;
        logic        redir;
        logic [2:0]  sext;
        logic [3:0]  ctl;
        logic [3:0]  fwd;
    } vec_t;

    vec_t tv[16];

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, 5'd6, op};
    endfunction

    function automatic vec_t mkv(
        input logic idv, input logic [31:0] inst,
        input logic exv, input logic exwe, input logic exld, input logic [4:0] exrd,
        input logic memv, input logic memwe, input logic [4:0] memrd,
        input logic redir, input logic [2:0] sext, input logic [3:0] ctl,
        input logic [3:0] fwd);
        vec_t v;
        v.idv = idv;   v.inst = inst;
        v.exv = exv;   v.exwe = exwe;   v.exld = exld;  v.exrd = exrd;
        v.memv = memv; v.memwe = memwe; v.memrd = memrd;
        v.redir = redir; v.sext = sext; v.ctl = ctl; v.fwd = fwd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid   = v.idv;   id_inst   = v.inst;
        ex_valid   = v.exv;   ex_rf_we  = v.exwe; ex_is_load = v.exld; ex_rd = v.exrd;
        mem_valid  = v.memv;  mem_rf_we = v.memwe; mem_rd = v.memrd;
        ex_redirect = v.redir;
    endtask

    function automatic logic [3:0] ctl_now();
        return {pc_stall, ifid_stall, ifid_flush, idex_flush};
    endfunction

    vec_t lu;

    initial begin
        // Table runs in order; vectors 8 and 13 execute in the STALL state.
        tv[0]  = mkv(1, mk(c_I, 1, 0),  0,0,0,0,  0,0,0, 0, c_EXT_I,    c_CTL_NONE,  4'b0000);
        tv[1]  = mkv(1, mk(c_S, 2, 3),  1,1,0,3,  0,0,0, 0, c_EXT_S,    c_CTL_NONE,  4'b0001);
        tv[2]  = mkv(1, mk(c_B, 4, 5),  0,0,0,0,  1,1,4, 0, c_EXT_B,    c_CTL_NONE,  4'b1000);
        tv[3]  = mkv(1, mk(c_LU, 7, 7), 1,1,0,7,  0,0,0, 0, c_EXT_U,    c_CTL_NONE,  4'b0000);
        tv[4]  = mkv(1, mk(c_J, 7, 7),  0,0,0,0,  1,1,7, 0, c_EXT_J,    c_CTL_NONE,  4'b0000);
        tv[5]  = mkv(1, mk(c_R, 3, 3),  1,1,0,3,  1,1,3, 0, c_EXT_NONE, c_CTL_NONE,  4'b0101);
        tv[6]  = mkv(1, mk(c_R, 0, 0),  1,1,0,0,  1,1,0, 0, c_EXT_NONE, c_CTL_NONE,  4'b0000);
        tv[7]  = mkv(1, mk(c_R, 5, 1),  1,1,1,5,  0,0,0, 0, c_EXT_NONE, c_CTL_STALL, 4'b0000);
        tv[8]  = mkv(1, mk(c_R, 5, 1),  1,1,1,5,  0,0,0, 0, c_EXT_NONE, c_CTL_NONE,  4'b0100);
        tv[9]  = mkv(0, mk(c_R, 1, 6),  1,1,1,6,  0,0,0, 0, c_EXT_NONE, c_CTL_NONE,  4'b0001);
        tv[10] = mkv(1, mk(c_R, 6, 0),  1,0,1,6,  0,0,0, 0, c_EXT_NONE, c_CTL_NONE,  4'b0000);
        tv[11] = mkv(1, mk(c_R, 5, 1),  1,1,1,5,  0,0,0, 1, c_EXT_NONE, c_CTL_REDIR, 4'b0000);
        tv[12] = mkv(1, mk(c_JR, 9, 0), 1,1,1,9,  0,0,0, 0, c_EXT_I,    c_CTL_STALL, 4'b0000);
        tv[13] = mkv(1, mk(c_JR, 9, 0), 1,1,1,9,  0,0,0, 1, c_EXT_I,    c_CTL_REDIR, 4'b0000);
        tv[14] = mkv(1, mk(c_LD, 2, 0), 0,0,0,0,  0,1,2, 0, c_EXT_I,    c_CTL_NONE,  4'b0000);
        tv[15] = mkv(1, mk(c_AU, 2, 2), 1,1,0,2,  1,1,2, 0, c_EXT_U,    c_CTL_NONE,  4'b0000);

        // Reset with both a load-use and a redirect present on the inputs.
        lu = mkv(1, mk(c_R, 5, 1), 1,1,1,5, 0,0,0, 0, c_EXT_NONE, c_CTL_STALL, 4'b0000);
        rst_n = 1'b0;
        drive(lu);
        ex_redirect = 1'b1;
        id_inst = mk(c_S, 5, 1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl",  {28'd0, ctl_now()}, 32'd0);
        check("rst_sext", {29'd0, sext_op}, {29'd0, c_EXT_S});
        check("rst_fwd",  {28'd0, fwd_a_ex, fwd_b_ex}, 32'd0);
        check("rst_cnt",  {stall_cnt, flush_cnt}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(tv[i]);
            #1;
            check($sformatf("v%0d_sext", i), {29'd0, sext_op}, {29'd0, tv[i].sext});
            check($sformatf("v%0d_ctl", i),  {28'd0, ctl_now()}, {28'd0, tv[i].ctl});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_fwd", i), {28'd0, fwd_a_ex, fwd_b_ex}, {28'd0, tv[i].fwd});
            @(negedge clk);
        end
        check("tbl_stall_cnt", {16'd0, stall_cnt}, 32'd2);
        check("tbl_flush_cnt", {16'd0, flush_cnt}, 32'd2);

        // Load-use: one bubble, then the loaded value comes from WB.
        drive(lu);
        #1;
        check("lu_ctl", {28'd0, ctl_now()}, {28'd0, c_CTL_STALL});
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        mem_valid = 1'b1; mem_rf_we = 1'b1; mem_rd = 5'd5;
        #1;
        check("lu_stall_ctl", {28'd0, ctl_now()}, 32'd0);
        check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        @(posedge clk);
        #1;
        check("lu_fwd", {28'd0, fwd_a_ex, fwd_b_ex}, 32'b1000);

        // Reset taken while in STALL must land in RUN with counters cleared.
        @(negedge clk);
        drive(lu);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_stall_cnt", {stall_cnt, flush_cnt}, 32'd0);
        check("rst_stall_run", {28'd0, ctl_now()}, {28'd0, c_CTL_STALL});

        // Flush counter saturation.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ex_redirect = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_pre", {16'd0, flush_cnt}, 32'h0000FFFE);
        repeat (6) @(posedge clk);
        #1;
        check("sat_hold", {16'd0, flush_cnt}, 32'h0000FFFF);
        check("sat_stall", {16'd0, stall_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline hazard and immediate-control unit for the 5-stage miniRV core; sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline registers. It selects the immediate-extension mode for the ID-stage sign-extender from the decoded opcode. It inserts a one-cycle bubble on load-use hazards and flushes wrong-path instructions on EX-stage redirects. It also registers forwarding selects into the EX stage and keeps saturating stall/flush event counters.

## Interface
- No parameters.
- cpu_clk  in  1  core clock; all state updates on rising edge.
- cpu_rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_inst  in  32  ID instruction; opcode [6:0], rs1 [19:15], rs2 [24:20].
- ex_valid, ex_rf_we, ex_is_load  in  1 each  EX-stage instruction valid / writes RF / is a load.
- ex_rd  in  5  EX-stage destination register.
- mem_valid, mem_rf_we  in  1 each;  mem_rd  in  5  MEM-stage producer.
- ex_redirect  in  1  EX resolved taken branch/jal/jalr this cycle.
- sext_op  out  3  EXT_* code from defines.vh for the ID sign-extender (combinational).
- pc_stall, ifid_stall  out  1  hold PC / IF/ID this cycle (combinational).
- ifid_flush, idex_flush  out  1  load NOP into IF/ID / ID/EX at next edge (combinational).
- fwd_a_ex, fwd_b_ex  out  2  registered operand-source selects valid in EX: 00 RF, 01 MEM result, 10 WB result.
- stall_cnt, flush_cnt  out  16  saturating event counters.

## Operation
- Opcode decode: 0010011/0000011/1100111 -> EXT_I; 0100011 -> EXT_S; 1100011 -> EXT_B; 0110111/0010111 -> EXT_U; 1101111 -> EXT_J; else default code (zero immediate).
- uses_rs1: all opcodes except 0110111, 0010111, 1101111. uses_rs2: 0110011, 0100011, 1100011.
- match_x(rs): x_valid & x_rf_we & x_rd!=0 & x_rd==rs, with x = ex or mem. Register x0 never matches.
- load_use = state==RUN & id_valid & ex_valid & ex_is_load & ex_rf_we & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- Priority: ex_redirect > load_use > normal.
  - ex_redirect: ifid_flush=1, idex_flush=1, stalls=0; flush_cnt++; next state RUN.
  - load_use: pc_stall=ifid_stall=1, idex_flush=1 (bubble); stall_cnt++; next state STALL.
  - Otherwise all control outputs 0.
- FSM: RUN -> STALL on load_use. STALL -> RUN unconditionally after 1 cycle. In STALL no load_use is raised (the load has advanced to MEM). ex_redirect in STALL flushes and returns to RUN.
- Forward selects, updated each edge:
  - if idex_flush=1, fwd_*_ex <= 00;
  - else per operand, if uses_rsN & match_ex(rsN) then 01 (producer will be in MEM); else if uses_rsN & match_mem(rsN) then 10; else 00.
  - EX match wins over MEM match.
- Counters increment by 1 per event cycle and hold at 0xFFFF.

## Timing
- Reset (cpu_rst_n=0 at edge): state=RUN, fwd_a_ex=fwd_b_ex=00, stall_cnt=flush_cnt=0. Combinational outputs follow their inputs during reset, except stall/flush, which are forced to 0 while cpu_rst_n=0.
- Reset asserted while in STALL: returns to RUN at that edge; no count.
- Combinational outputs respond in the same cycle as their inputs; the pipeline registers act at the following edge.
- fwd_*_ex latency: 1 cycle, aligned with the ID/EX register load.
- Load-use costs exactly 1 bubble cycle. The dependent instruction then sees fwd=10 for the loaded register.
- ex_redirect together with load_use: redirect only; stall_cnt is unchanged.

## Test plan
- Reset: drive cpu_rst_n=0 for 2 cycles -> all registered outputs 0, state RUN, stall/flush 0.
- sext_op: id_inst opcodes 0010011, 0100011, 1100011, 0110111, 1101111, 0110011 -> EXT_I, EXT_S, EXT_B, EXT_U, EXT_J, default.
- Load-use: EX lw x5 (ex_is_load=1, ex_rd=5), ID add x6,x5,x1 -> pc_stall=ifid_stall=idex_flush=1 for 1 cycle, stall_cnt=1. Next edge after stall: fwd_a_ex=10.
- Forwarding priority: ex_rd=3 and mem_rd=3 both writing, ID rs2=3 with opcode 0110011 -> fwd_b_ex=01 next cycle. With rd=0 on both -> 00.
- Redirect over load_use: ex_redirect=1 with a load-use condition present -> ifid_flush=idex_flush=1, pc_stall=0, flush_cnt+1, stall_cnt unchanged, fwd_*_ex=00.
- Saturation: apply 65 540 redirect cycles -> flush_cnt holds 0xFFFF.
